rib_rr_bus: RTL and testbench
=============================

RIB_RR_BUS -- requirements
Module: rib_rr_bus

Interface
REQ-001 Parameter MASTER_NUM, default 4, number of masters, legal range 2..8.
REQ-002 Parameter SLAVE_NUM, default 5, number of slaves, legal range 1..16.
REQ-003 Parameter DATA_W, default 32, data width, multiple of 8.
REQ-004 Port clk, input, 1, the single clock. There is one clock; reset is synchronous and active-high.
REQ-005 Port rst, input, 1, synchronous active-high reset.
REQ-006 Port m_addr_i, input, 32*MASTER_NUM, per-master address; master k occupies slice k.
REQ-007 Port m_data_i, input, DATA_W*MASTER_NUM, per-master write data.
REQ-008 Port m_sel_i, input, (DATA_W/8)*MASTER_NUM, per-master byte enables.
REQ-009 Ports m_we_i, m_req_vld_i and m_rsp_rdy_i, input, MASTER_NUM each, per-master write, request-valid and response-ready.
REQ-010 Ports m_req_rdy_o, m_rsp_vld_o and m_rsp_err_o, output, MASTER_NUM each, per-master request-ready, response-valid and error flag.
REQ-011 Port m_data_o, output, DATA_W*MASTER_NUM, per-master read data.
REQ-012 Ports s_addr_o, s_data_o, s_sel_o, s_we_o, s_req_vld_o and s_rsp_rdy_o, output, per-slave packed (slice j = slave j), widths 32/DATA_W/DATA_W/8/1/1.
REQ-013 Ports s_data_i, s_req_rdy_i and s_rsp_vld_i, input, per-slave packed, widths DATA_W/1/1.

Function
REQ-014 The arbiter SHALL be round-robin: the search starts at pointer rr_ptr; the first requesting master at or after rr_ptr (modulo MASTER_NUM) wins.
REQ-015 FSM states SHALL be IDLE, REQ, RSP and ERR.
REQ-016 IDLE: if any m_req_vld_i is high, the bus SHALL register grant_id and slave_id (the winner's addr[31:28]) and move to REQ next cycle; this gives 1 cycle of arbitration latency.
REQ-017 REQ with a mapped slave (slave_id < SLAVE_NUM): the granted master's addr/data/sel/we/req_vld SHALL route combinationally to slave slave_id only.
- s addr = {4'h0, addr[27:0]}.
- m_req_rdy_o[grant] = s_req_rdy_i[slave_id].
- Move to RSP on the req_vld&req_rdy handshake.
REQ-018 REQ with an unmapped slave (slave_id >= SLAVE_NUM): no slave signal SHALL assert; m_req_rdy_o[grant]=1 for one cycle, then move to ERR.
REQ-019 If the granted master drops m_req_vld_i in REQ before the handshake, the bus SHALL return to IDLE with no slave response and advance rr_ptr.
REQ-020 RSP: s_rsp_rdy_o[slave_id] = m_rsp_rdy_i[grant]; m_rsp_vld_o[grant] = s_rsp_vld_i[slave_id]; m_data_o[grant] = s_data_i[slave_id].
REQ-021 RSP SHALL move to IDLE on the rsp_vld&rsp_rdy handshake.
REQ-022 ERR: m_rsp_vld_o[grant]=1, m_rsp_err_o[grant]=1, data 0; move to IDLE when m_rsp_rdy_i[grant] is high.
REQ-023 On every return to IDLE, rr_ptr SHALL become (grant_id+1) mod MASTER_NUM, wrapping from MASTER_NUM-1 to 0.
REQ-024 The grant SHALL be locked from the IDLE exit until the return to IDLE; requests from other masters SHALL be ignored while locked.
REQ-025 The bus SHALL allow one outstanding transaction in total; back-to-back transactions SHALL reach a throughput of one per 3 cycles when slaves respond with zero wait states.
REQ-026 All non-granted master outputs and all unselected slave outputs SHALL be 0 in every state.
REQ-027 In IDLE, all outputs SHALL be 0.
REQ-028 A slave response arriving in REQ (before req_rdy) SHALL be ignored.
REQ-029 m_rsp_err_o SHALL be 0 outside ERR.

Reset
REQ-030 When rst is high at a clk edge, the bus SHALL enter IDLE with rr_ptr=0, grant_id=0 and slave_id=0; all outputs SHALL be 0 in the following cycle.
REQ-031 A reset in REQ, RSP or ERR SHALL abort the transaction with no completion signalled to the master.

Structure
REQ-032 Shared package rib_pkg SHALL hold:
- the state enum;
- SLV_ID_W=4 and the decode field position 31:28;
- the error read-data constant (0).
REQ-033 Sub-module rib_rr_arbiter (request vector plus pointer in, one-hot grant and index out, combinational) SHALL be instantiated once.

Verification
REQ-034 M0 and M2 request in the same cycle with rr_ptr=0 -> M0 is granted first, M2 after M0's response, and rr_ptr=3.
REQ-035 With all 4 masters requesting continuously -> grants follow 0,1,2,3,0 with no starvation.
REQ-036 M1 reads 0x2000_0010 while s2 returns 0xDEAD_BEEF -> s2 sees addr 0x0000_0010 and M1 receives 0xDEAD_BEEF with err=0.
REQ-037 M3 accesses 0xF000_0000 with SLAVE_NUM=5 -> no slave req_vld asserts, and M3 gets rsp_vld=1, err=1, data 0 on the second cycle after grant.
REQ-038 Slave holds req_rdy=0 for 5 cycles while M1 requests during that time -> the grant stays with M0 and M1 is served next.
REQ-039 rst asserted in RSP -> next cycle is IDLE, all outputs are 0 and rr_ptr=0.

Source files
------------

// File: rtl/rib_pkg.sv
// Shared types and constants for the round-robin request/response bus.
package rib_pkg;

    // Bus controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2,
        ERR  = 2'd3
    } rib_state_e;

    // Address width and the slave-decode field.
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned SLV_ID_W = 4;
    localparam int unsigned DEC_HI   = 31;
    localparam int unsigned DEC_LO   = 28;

    // Read data returned on a decode error.
    localparam logic [31:0] ERR_RDATA = 32'h0000_0000;

endpackage

// File: rtl/rib_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rib_rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant_oh,
    output logic [IDX_W-1:0] grant_idx
);

    int unsigned cand;
    logic        found;

    // Scan N candidates starting at ptr; the first active request wins.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = 32'(ptr) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!found && req[IDX_W'(cand)]) begin
                found                     = 1'b1;
                grant_oh[IDX_W'(cand)]    = 1'b1;
                grant_idx                 = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/rib_rr_bus.sv
// Multi-master, multi-slave bus with round-robin arbitration and one
// outstanding transaction; unmapped addresses complete with an error.
module rib_rr_bus
    import rib_pkg::*;
#(
    parameter int unsigned MASTER_NUM = 4,
    parameter int unsigned SLAVE_NUM  = 5,
    parameter int unsigned DATA_W     = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [ADDR_W*MASTER_NUM-1:0]       m_addr_i,
    input  logic [DATA_W*MASTER_NUM-1:0]       m_data_i,
    input  logic [(DATA_W/8)*MASTER_NUM-1:0]   m_sel_i,
    input  logic [MASTER_NUM-1:0]              m_we_i,
    input  logic [MASTER_NUM-1:0]              m_req_vld_i,
    input  logic [MASTER_NUM-1:0]              m_rsp_rdy_i,
    output logic [MASTER_NUM-1:0]              m_req_rdy_o,
    output logic [MASTER_NUM-1:0]              m_rsp_vld_o,
    output logic [MASTER_NUM-1:0]              m_rsp_err_o,
    output logic [DATA_W*MASTER_NUM-1:0]       m_data_o,
    output logic [ADDR_W*SLAVE_NUM-1:0]        s_addr_o,
    output logic [DATA_W*SLAVE_NUM-1:0]        s_data_o,
    output logic [(DATA_W/8)*SLAVE_NUM-1:0]    s_sel_o,
    output logic [SLAVE_NUM-1:0]               s_we_o,
    output logic [SLAVE_NUM-1:0]               s_req_vld_o,
    output logic [SLAVE_NUM-1:0]               s_rsp_rdy_o,
    input  logic [DATA_W*SLAVE_NUM-1:0]        s_data_i,
    input  logic [SLAVE_NUM-1:0]               s_req_rdy_i,
    input  logic [SLAVE_NUM-1:0]               s_rsp_vld_i
);

    localparam int unsigned SEL_W = DATA_W / 8;
    localparam int unsigned GNT_W = $clog2(MASTER_NUM);
    localparam int unsigned OFS_W = DEC_LO;

    rib_state_e            state_q, state_d;
    logic [GNT_W-1:0]      grant_q, grant_d;
    logic [GNT_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [GNT_W-1:0]      arb_idx, ptr_inc;
    logic [MASTER_NUM-1:0] arb_oh;
    logic [SLV_ID_W-1:0]   slave_q, slave_d, win_slv;
    logic                  slv_mapped, acc_rdy;

    logic [OFS_W-1:0]      g_ofs;
    logic [DATA_W-1:0]     g_data;
    logic [SEL_W-1:0]      g_sel;
    logic                  g_we, g_req_vld, g_rsp_rdy;

    logic [DATA_W-1:0]     sv_data;
    logic                  sv_req_rdy, sv_rsp_vld;

    logic                  req_route_c, rsp_route_c;
    logic                  m_req_rdy_c, m_rsp_vld_c, m_rsp_err_c;
    logic [DATA_W-1:0]     m_data_c;

    rib_rr_arbiter #(
        .N     (MASTER_NUM),
        .IDX_W (GNT_W)
    ) u_arb (
        .req       (m_req_vld_i),
        .ptr       (rr_ptr_q),
        .grant_oh  (arb_oh),
        .grant_idx (arb_idx)
    );

    // Decode field of the arbitration winner's address.
    always_comb begin
        win_slv = '0;
        for (int unsigned k = 0; k < MASTER_NUM; k++) begin
            if (arb_oh[k]) begin
                win_slv = m_addr_i[k*ADDR_W + DEC_LO +: SLV_ID_W];
            end
        end
    end

    assign slv_mapped = (32'(slave_q) < SLAVE_NUM);
    assign ptr_inc    = (grant_q == GNT_W'(MASTER_NUM - 1)) ? '0 : grant_q + GNT_W'(1);
    assign acc_rdy    = slv_mapped ? sv_req_rdy : 1'b1;

    // Select the locked master's request-side signals.
    always_comb begin
        g_ofs     = '0;
        g_data    = '0;
        g_sel     = '0;
        g_we      = 1'b0;
        g_req_vld = 1'b0;
        g_rsp_rdy = 1'b0;
        for (int unsigned k = 0; k < MASTER_NUM; k++) begin
            if (grant_q == GNT_W'(k)) begin
                g_ofs     = m_addr_i[k*ADDR_W +: OFS_W];
                g_data    = m_data_i[k*DATA_W +: DATA_W];
                g_sel     = m_sel_i[k*SEL_W +: SEL_W];
                g_we      = m_we_i[k];
                g_req_vld = m_req_vld_i[k];
                g_rsp_rdy = m_rsp_rdy_i[k];
            end
        end
    end

    // Select the addressed slave's response-side signals.
    always_comb begin
        sv_data    = '0;
        sv_req_rdy = 1'b0;
        sv_rsp_vld = 1'b0;
        for (int unsigned j = 0; j < SLAVE_NUM; j++) begin
            if (slave_q == SLV_ID_W'(j)) begin
                sv_data    = s_data_i[j*DATA_W +: DATA_W];
                sv_req_rdy = s_req_rdy_i[j];
                sv_rsp_vld = s_rsp_vld_i[j];
            end
        end
    end

    // State, grant lock and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            slave_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            slave_q  <= slave_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Next-state logic and per-state routing intent.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        slave_d     = slave_q;
        rr_ptr_d    = rr_ptr_q;
        req_route_c = 1'b0;
        rsp_route_c = 1'b0;
        m_req_rdy_c = 1'b0;
        m_rsp_vld_c = 1'b0;
        m_rsp_err_c = 1'b0;
        m_data_c    = '0;
        case (state_q)
            IDLE: begin
                if (|m_req_vld_i) begin
                    state_d = REQ;
                    grant_d = arb_idx;
                    slave_d = win_slv;
                end
            end
            REQ: begin
                req_route_c = slv_mapped;
                m_req_rdy_c = acc_rdy;
                if (!g_req_vld) begin
                    state_d  = IDLE;
                    rr_ptr_d = ptr_inc;
                end else if (acc_rdy) begin
                    state_d = slv_mapped ? RSP : ERR;
                end
            end
            RSP: begin
                rsp_route_c = 1'b1;
                m_rsp_vld_c = sv_rsp_vld;
                m_data_c    = sv_data;
                if (sv_rsp_vld && g_rsp_rdy) begin
                    state_d  = IDLE;
                    rr_ptr_d = ptr_inc;
                end
            end
            ERR: begin
                m_rsp_vld_c = 1'b1;
                m_rsp_err_c = 1'b1;
                m_data_c    = DATA_W'(ERR_RDATA);
                if (g_rsp_rdy) begin
                    state_d  = IDLE;
                    rr_ptr_d = ptr_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Drive only the granted master's outputs; all others stay 0.
    always_comb begin
        m_req_rdy_o = '0;
        m_rsp_vld_o = '0;
        m_rsp_err_o = '0;
        m_data_o    = '0;
        for (int unsigned k = 0; k < MASTER_NUM; k++) begin
            if (grant_q == GNT_W'(k)) begin
                m_req_rdy_o[k]                = m_req_rdy_c;
                m_rsp_vld_o[k]                = m_rsp_vld_c;
                m_rsp_err_o[k]                = m_rsp_err_c;
                m_data_o[k*DATA_W +: DATA_W]  = m_data_c;
            end
        end
    end

    // Drive only the addressed slave's outputs; all others stay 0.
    always_comb begin
        s_addr_o    = '0;
        s_data_o    = '0;
        s_sel_o     = '0;
        s_we_o      = '0;
        s_req_vld_o = '0;
        s_rsp_rdy_o = '0;
        for (int unsigned j = 0; j < SLAVE_NUM; j++) begin
            if (slave_q == SLV_ID_W'(j)) begin
                if (req_route_c) begin
                    s_addr_o[j*ADDR_W +: ADDR_W] = {SLV_ID_W'(0), g_ofs};
                    s_data_o[j*DATA_W +: DATA_W] = g_data;
                    s_sel_o[j*SEL_W +: SEL_W]    = g_sel;
                    s_we_o[j]                    = g_we;
                    s_req_vld_o[j]               = g_req_vld;
                end
                s_rsp_rdy_o[j] = rsp_route_c & g_rsp_rdy;
            end
        end
    end

endmodule

// File: tb/tb_rib_rr_bus.sv
// Randomized bench for rib_rr_bus against a transaction-level reference model.
module tb_rib_rr_bus;

    localparam int MN = 4;
    localparam int SN = 5;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int NCYC = 4000;

    logic clk, rst;
    logic [32*MN-1:0] m_addr_i;
    logic [DW*MN-1:0] m_data_i;
    logic [SW*MN-1:0] m_sel_i;
    logic [MN-1:0]    m_we_i, m_req_vld_i, m_rsp_rdy_i;
    logic [MN-1:0]    m_req_rdy_o, m_rsp_vld_o, m_rsp_err_o;
    logic [DW*MN-1:0] m_data_o;
    logic [32*SN-1:0] s_addr_o;
    logic [DW*SN-1:0] s_data_o;
    logic [SW*SN-1:0] s_sel_o;
    logic [SN-1:0]    s_we_o, s_req_vld_o, s_rsp_rdy_o;
    logic [DW*SN-1:0] s_data_i;
    logic [SN-1:0]    s_req_rdy_i, s_rsp_vld_i;

    rib_rr_bus #(.MASTER_NUM(MN), .SLAVE_NUM(SN), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .m_addr_i(m_addr_i), .m_data_i(m_data_i), .m_sel_i(m_sel_i),
        .m_we_i(m_we_i), .m_req_vld_i(m_req_vld_i), .m_rsp_rdy_i(m_rsp_rdy_i),
        .m_req_rdy_o(m_req_rdy_o), .m_rsp_vld_o(m_rsp_vld_o),
        .m_rsp_err_o(m_rsp_err_o), .m_data_o(m_data_o),
        .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_sel_o(s_sel_o),
        .s_we_o(s_we_o), .s_req_vld_o(s_req_vld_o), .s_rsp_rdy_o(s_rsp_rdy_o),
        .s_data_i(s_data_i), .s_req_rdy_i(s_req_rdy_i), .s_rsp_vld_i(s_rsp_vld_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: one transaction record (owner, target, phase) plus pointer.
    bit m_free;
    int m_own, m_slv, m_phase, m_ptr;
    int n_done, n_errtxn;
    bit mapped;

    function automatic int rr_pick(input logic [MN-1:0] req, input int ptr);
        for (int i = 0; i < MN; i++) begin
            if (req[(ptr + i) % MN]) return (ptr + i) % MN;
        end
        return 0;
    endfunction

    // Master and slave agent state.
    bit        pend [MN];
    bit        wait_rsp [MN];
    bit        sbusy [SN];
    int        sdly [SN];
    logic [DW-1:0] sdata [SN];
    logic [3:0] sid;

    logic [MN-1:0]    e_req_rdy, e_rsp_vld, e_rsp_err;
    logic [DW*MN-1:0] e_mdata;
    logic [32*SN-1:0] e_saddr;
    logic [DW*SN-1:0] e_sdata;
    logic [SW*SN-1:0] e_ssel;
    logic [SN-1:0]    e_swe, e_sreq, e_srsp;

    initial begin
        rst = 1'b1;
        m_addr_i = '0; m_data_i = '0; m_sel_i = '0; m_we_i = '0;
        m_req_vld_i = '0; m_rsp_rdy_i = '0;
        s_data_i = '0; s_req_rdy_i = '0; s_rsp_vld_i = '0;
        m_free = 1'b1; m_ptr = 0; m_own = 0; m_slv = 0; m_phase = 0;
        n_done = 0; n_errtxn = 0;
        for (int k = 0; k < MN; k++) begin pend[k] = 0; wait_rsp[k] = 0; end
        for (int j = 0; j < SN; j++) begin sbusy[j] = 0; sdly[j] = 0; sdata[j] = '0; end

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            // Drive this cycle's inputs.
            rst = (cyc < 3) || ($urandom_range(0, 499) == 0);
            for (int k = 0; k < MN; k++) begin
                if (!pend[k] && !wait_rsp[k] && $urandom_range(0, 1) == 0) begin
                    pend[k] = 1;
                    sid = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(5, 15))
                                                      : 4'($urandom_range(0, SN - 1));
                    m_addr_i[k*32 +: 32] = {sid, 28'($urandom)};
                    m_data_i[k*DW +: DW] = DW'($urandom);
                    m_sel_i[k*SW +: SW]  = SW'($urandom);
                    m_we_i[k]            = 1'($urandom);
                end else if (pend[k] && $urandom_range(0, 29) == 0) begin
                    pend[k] = 0;
                end
                m_req_vld_i[k] = pend[k];
                m_rsp_rdy_i[k] = ($urandom_range(0, 2) != 0);
            end
            for (int j = 0; j < SN; j++) begin
                s_req_rdy_i[j] = ($urandom_range(0, 2) != 0);
                if (sbusy[j] && sdly[j] == 0) begin
                    s_rsp_vld_i[j]        = 1'b1;
                    s_data_i[j*DW +: DW]  = sdata[j];
                end else begin
                    if (sbusy[j]) sdly[j]--;
                    s_rsp_vld_i[j]        = !sbusy[j] && ($urandom_range(0, 3) == 0);
                    s_data_i[j*DW +: DW]  = DW'($urandom);
                end
            end
            #1;

            // Expected outputs from the model's transaction record.
            e_req_rdy = '0; e_rsp_vld = '0; e_rsp_err = '0; e_mdata = '0;
            e_saddr = '0; e_sdata = '0; e_ssel = '0; e_swe = '0; e_sreq = '0; e_srsp = '0;
            mapped = (m_slv < SN);
            if (!m_free) begin
                if (m_phase == 1) begin
                    if (mapped) begin
                        e_req_rdy[m_own]        = s_req_rdy_i[m_slv];
                        e_sreq[m_slv]           = m_req_vld_i[m_own];
                        e_saddr[m_slv*32 +: 32] = {4'h0, m_addr_i[m_own*32 +: 28]};
                        e_sdata[m_slv*DW +: DW] = m_data_i[m_own*DW +: DW];
                        e_ssel[m_slv*SW +: SW]  = m_sel_i[m_own*SW +: SW];
                        e_swe[m_slv]            = m_we_i[m_own];
                    end else begin
                        e_req_rdy[m_own] = 1'b1;
                    end
                end else begin
                    if (mapped) begin
                        e_rsp_vld[m_own]        = s_rsp_vld_i[m_slv];
                        e_srsp[m_slv]           = m_rsp_rdy_i[m_own];
                        e_mdata[m_own*DW +: DW] = s_data_i[m_slv*DW +: DW];
                    end else begin
                        e_rsp_vld[m_own] = 1'b1;
                        e_rsp_err[m_own] = 1'b1;
                    end
                end
            end
            chk($sformatf("m_req_rdy@%0d", cyc), 256'(m_req_rdy_o), 256'(e_req_rdy));
            chk($sformatf("m_rsp_vld@%0d", cyc), 256'(m_rsp_vld_o), 256'(e_rsp_vld));
            chk($sformatf("m_rsp_err@%0d", cyc), 256'(m_rsp_err_o), 256'(e_rsp_err));
            chk($sformatf("m_data@%0d", cyc),    256'(m_data_o),    256'(e_mdata));
            chk($sformatf("s_addr@%0d", cyc),    256'(s_addr_o),    256'(e_saddr));
            chk($sformatf("s_data@%0d", cyc),    256'(s_data_o),    256'(e_sdata));
            chk($sformatf("s_sel@%0d", cyc),     256'(s_sel_o),     256'(e_ssel));
            chk($sformatf("s_we@%0d", cyc),      256'(s_we_o),      256'(e_swe));
            chk($sformatf("s_req_vld@%0d", cyc), 256'(s_req_vld_o), 256'(e_sreq));
            chk($sformatf("s_rsp_rdy@%0d", cyc), 256'(s_rsp_rdy_o), 256'(e_srsp));

            // Advance the model using this cycle's inputs.
            if (rst) begin
                m_free = 1'b1;
                m_ptr  = 0;
            end else if (m_free) begin
                if (|m_req_vld_i) begin
                    m_own   = rr_pick(m_req_vld_i, m_ptr);
                    m_slv   = int'(m_addr_i[m_own*32 + 28 +: 4]);
                    m_free  = 1'b0;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (!m_req_vld_i[m_own]) begin
                    m_free = 1'b1;
                    m_ptr  = (m_own + 1) % MN;
                end else if (!mapped || s_req_rdy_i[m_slv]) begin
                    m_phase = 2;
                end
            end else begin
                if (mapped ? (s_rsp_vld_i[m_slv] && m_rsp_rdy_i[m_own]) : m_rsp_rdy_i[m_own]) begin
                    m_free = 1'b1;
                    m_ptr  = (m_own + 1) % MN;
                    n_done++;
                    if (!mapped) n_errtxn++;
                end
            end

            // Advance the agents.
            for (int k = 0; k < MN; k++) begin
                if (m_req_vld_i[k] && m_req_rdy_o[k]) begin
                    pend[k] = 0;
                    wait_rsp[k] = 1;
                end
                if (wait_rsp[k] && m_rsp_vld_o[k] && m_rsp_rdy_i[k]) wait_rsp[k] = 0;
                if (rst) begin pend[k] = 0; wait_rsp[k] = 0; end
            end
            for (int j = 0; j < SN; j++) begin
                if (s_rsp_vld_i[j] && s_rsp_rdy_o[j]) sbusy[j] = 0;
                if (s_req_vld_o[j] && s_req_rdy_i[j]) begin
                    sbusy[j] = 1;
                    sdly[j]  = $urandom_range(0, 2);
                    sdata[j] = DW'($urandom);
                end
                if (rst) sbusy[j] = 0;
            end
        end

        chk("completed_txns_min", 256'(n_done >= 50), 256'(1));
        chk("error_txns_min",     256'(n_errtxn >= 5), 256'(1));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
